// File: rtl/syscall_unit.sv
// Services SYSCALL requests retiring from writeback: console print of int/char/string, or halt.
// Stalls the pipeline from the accept cycle until the DONE cycle; the HALT state stalls until reset.
module syscall_unit #(
    parameter int unsigned MAX_STR = 256
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        syscall_in_i,
    input  logic [31:0] v0_i,
    input  logic [31:0] a0_i,
    output logic        stall_o,
    output logic        mem_rd_o,
    output logic [31:0] mem_addr_o,
    input  logic [31:0] mem_rdata_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic        out_type_o,
    output logic [31:0] out_data_o,
    output logic        halted_o,
    output logic        bad_code_o
);
    localparam int CNT_W = $clog2(MAX_STR + 1);

    typedef enum logic [2:0] {
        IDLE, EMIT, STR_REQ, STR_WAIT, STR_EMIT, DONE, HALT
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      ptr_q, ptr_d;
    logic [31:0]      data_q, data_d;
    logic             type_q, type_d;
    logic             bad_q, bad_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       byte_sel;

    // Strings are stored big-endian within each word.
    always_comb begin
        case (ptr_q[1:0])
            2'd0:    byte_sel = mem_rdata_i[31:24];
            2'd1:    byte_sel = mem_rdata_i[23:16];
            2'd2:    byte_sel = mem_rdata_i[15:8];
            default: byte_sel = mem_rdata_i[7:0];
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            data_q  <= '0;
            type_q  <= 1'b0;
            bad_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            data_q  <= data_d;
            type_q  <= type_d;
            bad_q   <= bad_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        data_d      = data_q;
        type_d      = type_q;
        bad_d       = bad_q;
        cnt_d       = cnt_q;
        stall_o     = 1'b0;
        mem_rd_o    = 1'b0;
        mem_addr_o  = '0;
        out_valid_o = 1'b0;
        case (state_q)
            IDLE: begin
                // Accept is gated by reset so a held syscall cannot restart during reset.
                if (syscall_in_i && rst_n_i) begin
                    ptr_d = a0_i;
                    cnt_d = '0;
                    case (v0_i)
                        32'd1: begin
                            state_d = EMIT;
                            type_d  = 1'b1;
                            data_d  = a0_i;
                            stall_o = 1'b1;
                        end
                        32'd11: begin
                            state_d = EMIT;
                            type_d  = 1'b0;
                            data_d  = {24'd0, a0_i[7:0]};
                            stall_o = 1'b1;
                        end
                        32'd4: begin
                            state_d = STR_REQ;
                            type_d  = 1'b0;
                            stall_o = 1'b1;
                        end
                        32'd10: begin
                            state_d = HALT;
                            stall_o = 1'b1;
                        end
                        default: bad_d = 1'b1;
                    endcase
                end
            end
            EMIT: begin
                stall_o     = 1'b1;
                out_valid_o = 1'b1;
                if (out_ready_i) state_d = DONE;
            end
            STR_REQ: begin
                stall_o    = 1'b1;
                mem_rd_o   = 1'b1;
                mem_addr_o = {ptr_q[31:2], 2'b00};
                state_d    = STR_WAIT;
            end
            STR_WAIT: begin
                stall_o = 1'b1;
                if (byte_sel == 8'd0 || cnt_q == CNT_W'(MAX_STR)) begin
                    state_d = DONE;
                end else begin
                    data_d  = {24'd0, byte_sel};
                    state_d = STR_EMIT;
                end
            end
            STR_EMIT: begin
                stall_o     = 1'b1;
                out_valid_o = 1'b1;
                if (out_ready_i) begin
                    ptr_d   = ptr_q + 32'd1;
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = STR_REQ;
                end
            end
            DONE:    state_d = IDLE;
            HALT:    stall_o = 1'b1;
            default: state_d = IDLE;
        endcase
    end

    assign out_type_o = type_q;
    assign out_data_o = data_q;
    assign halted_o   = (state_q == HALT);
    assign bad_code_o = bad_q;
endmodule

// File: tb/tb_syscall_unit.sv
// Bench for syscall_unit: directed vector table, hand-written corner sequences and a randomized run
// checked against a queue-based console/memory model.
module tb_syscall_unit;
    localparam int MAX = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        syscall_in = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] v0 = '0;
    logic [31:0] a0 = '0;
    logic [31:0] mem_rdata = '0;
    logic        stall, mem_rd, out_valid, out_type, halted, bad_code;
    logic [31:0] mem_addr, out_data;

    logic [31:0] mem [0:255];
    logic [32:0] exp_items [$];
    logic [31:0] exp_reads [$];
    bit          exp_bad = 1'b0;
    int          checks = 0;
    int          errors = 0;

    syscall_unit #(.MAX_STR(MAX)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .syscall_in_i(syscall_in), .v0_i(v0), .a0_i(a0),
        .stall_o(stall), .mem_rd_o(mem_rd), .mem_addr_o(mem_addr), .mem_rdata_i(mem_rdata),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_type_o(out_type),
        .out_data_o(out_data), .halted_o(halted), .bad_code_o(bad_code)
    );

    always #5 clk = ~clk;

    // Data memory: read data appears the cycle after the request.
    always @(posedge clk) if (mem_rd) mem_rdata <= mem[mem_addr[9:2]];

    task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%09h expected 0x%09h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    // Expected console items and read addresses of one request, straight from the service rules.
    function automatic void model(input logic [31:0] v, input logic [31:0] a);
        logic [31:0] p;
        logic [31:0] w;
        logic [7:0]  b;
        exp_items.delete();
        exp_reads.delete();
        case (v)
            32'd1:  exp_items.push_back({1'b1, a});
            32'd11: exp_items.push_back({1'b0, 24'd0, a[7:0]});
            32'd4: begin
                p = a;
                for (int n = 0; n <= MAX; n++) begin
                    exp_reads.push_back(p & 32'hFFFF_FFFC);
                    w = mem[p[9:2]];
                    b = w[8 * (3 - int'(p[1:0])) +: 8];
                    if (b == 8'd0 || n == MAX) break;
                    exp_items.push_back({1'b0, 24'd0, b});
                    p = p + 32'd1;
                end
            end
            default: ;
        endcase
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        syscall_in = 1'b0;
        out_ready = 1'b0;
        exp_bad = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst_stall", 33'(stall), 33'd0);
        check("rst_flags", 33'({mem_rd, out_valid, out_type, halted, bad_code}), 33'd0);
        check("rst_addr", 33'(mem_addr), 33'd0);
        check("rst_data", 33'(out_data), 33'd0);
        rst_n = 1'b1;
    endtask

    // Holds the syscall in writeback until stall drops (DONE or rejected code), checking every cycle.
    task automatic do_syscall(input logic [31:0] v, input logic [31:0] a, input int low, input bit rnd,
                              output int stall_cnt, output int waits);
        logic        prev_hold;
        logic [32:0] prev_item;
        bit          done;
        stall_cnt = 0;
        waits = 0;
        prev_hold = 1'b0;
        prev_item = '0;
        done = 1'b0;
        @(negedge clk);
        syscall_in = 1'b1;
        v0 = v;
        a0 = a;
        for (int c = 0; c < 3000; c++) begin
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'(c > low);
            #1;
            if (prev_hold) begin
                check("hold_valid", 33'(out_valid), 33'd1);
                check("hold_item", {out_type, out_data}, prev_item);
            end
            if (c == 1 && (v == 32'd1 || v == 32'd11)) check("first_valid", 33'(out_valid), 33'd1);
            if (c == 1 && v == 32'd4) check("first_read", 33'(mem_rd), 33'd1);
            if (mem_rd) begin
                if (exp_reads.size() == 0) fail("extra_read");
                else check("read_addr", 33'(mem_addr), 33'(exp_reads.pop_front()));
            end
            if (out_valid && out_ready) begin
                if (exp_items.size() == 0) fail("extra_item");
                else check("item", {out_type, out_data}, exp_items.pop_front());
            end
            if (out_valid && !out_ready) waits++;
            prev_hold = out_valid && !out_ready;
            prev_item = {out_type, out_data};
            if (!stall) begin
                done = 1'b1;
                break;
            end
            stall_cnt++;
            @(negedge clk);
        end
        if (!done) fail("stall_timeout");
        check("items_left", 33'(exp_items.size()), 33'd0);
        check("reads_left", 33'(exp_reads.size()), 33'd0);
        @(negedge clk);
        syscall_in = 1'b0;
        #1;
        check("idle_after", 33'({stall, out_valid, mem_rd}), 33'd0);
    endtask

    typedef struct {
        logic [31:0] v;
        logic [31:0] a;
        logic [32:0] item;
        int          stall_cycles;
    } vec_t;

    initial begin
        vec_t        tbl [5];
        int          sc, w, k, base, pick;
        bit          found;
        logic [31:0] v, a;

        tbl[0] = '{32'd1,  32'hDEADBEEF, {1'b1, 32'hDEADBEEF}, 2};
        tbl[1] = '{32'd11, 32'h12345641, {1'b0, 32'h00000041}, 2};
        tbl[2] = '{32'd1,  32'h00000000, {1'b1, 32'h00000000}, 2};
        tbl[3] = '{32'd11, 32'hFFFFFF80, {1'b0, 32'h00000080}, 2};
        tbl[4] = '{32'd1,  32'h7FFFFFFF, {1'b1, 32'h7FFFFFFF}, 2};

        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        do_reset();

        for (int i = 0; i < 5; i++) begin
            exp_items.delete();
            exp_reads.delete();
            exp_items.push_back(tbl[i].item);
            do_syscall(tbl[i].v, tbl[i].a, 0, 1'b0, sc, w);
            check("tbl_stall", 33'(sc), 33'(tbl[i].stall_cycles));
            check("tbl_bad", 33'(bad_code), 33'd0);
        end

        // Backpressure: ready low for 3 cycles.
        exp_items.delete();
        exp_reads.delete();
        exp_items.push_back({1'b0, 32'h41});
        do_syscall(32'd11, 32'h12345641, 3, 1'b0, sc, w);
        check("bp_stall", 33'(sc), 33'd5);
        check("bp_waits", 33'(w), 33'd3);

        // Two-character aligned string.
        mem[8'h40] = 32'h48690000;
        exp_items.delete();
        exp_reads.delete();
        exp_items.push_back({1'b0, 32'h48});
        exp_items.push_back({1'b0, 32'h69});
        repeat (3) exp_reads.push_back(32'h100);
        do_syscall(32'd4, 32'h100, 0, 1'b0, sc, w);
        check("str_stall", 33'(sc), 33'd9);

        // Unaligned start, truncated at MAX characters.
        mem[8'h40] = 32'h11223344;
        mem[8'h41] = 32'h45464748;
        mem[8'h42] = 32'h494A4B4C;
        mem[8'h43] = 32'h4D000000;
        exp_items.delete();
        exp_reads.delete();
        for (int i = 0; i < 4; i++) exp_items.push_back(33'(32'h44 + i));
        exp_reads.push_back(32'h100);
        repeat (4) exp_reads.push_back(32'h104);
        do_syscall(32'd4, 32'h103, 0, 1'b0, sc, w);
        check("trunc_stall", 33'(sc), 33'd15);

        // Reset while a string character is waiting for ready.
        @(negedge clk);
        syscall_in = 1'b1;
        v0 = 32'd4;
        a0 = 32'h104;
        out_ready = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (out_valid) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!found) fail("mid_str_timeout");
        check("mid_item", {out_type, out_data}, {1'b0, 32'h45});
        rst_n = 1'b0;
        syscall_in = 1'b0;
        @(negedge clk);
        #1;
        check("mid_rst_valid", 33'(out_valid), 33'd0);
        check("mid_rst_stall", 33'(stall), 33'd0);
        check("mid_rst_rd", 33'(mem_rd), 33'd0);
        rst_n = 1'b1;
        exp_items.delete();
        exp_reads.delete();
        exp_items.push_back({1'b1, 32'hCAFE0001});
        do_syscall(32'd1, 32'hCAFE0001, 0, 1'b0, sc, w);
        check("post_rst_stall", 33'(sc), 33'd2);

        // Exit: stall from the accept cycle, halted from the next, later syscalls ignored.
        @(negedge clk);
        syscall_in = 1'b1;
        v0 = 32'd10;
        out_ready = 1'b1;
        #1;
        check("exit_stall_n", 33'(stall), 33'd1);
        check("exit_halt_n", 33'(halted), 33'd0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            syscall_in = i[0];
            v0 = 32'd1;
            #1;
            check("halt_stall", 33'(stall), 33'd1);
            check("halt_flag", 33'(halted), 33'd1);
            check("halt_quiet", 33'({out_valid, mem_rd}), 33'd0);
        end
        do_reset();

        // Unsupported code: flagged, never stalls.
        exp_items.delete();
        exp_reads.delete();
        do_syscall(32'd7, 32'h0, 0, 1'b0, sc, w);
        check("bad_stall", 33'(sc), 33'd0);
        check("bad_flag", 33'(bad_code), 33'd1);
        do_reset();

        // Randomized run against the model.
        for (int i = 0; i < 256; i++) begin
            w = $urandom;
            for (int b = 0; b < 4; b++)
                if ($urandom_range(0, 4) == 0) mem[i][8*b +: 8] = 8'd0;
                else mem[i][8*b +: 8] = 8'(w >> (8 * b)) | 8'h01;
        end
        for (int i = 0; i < 60; i++) begin
            pick = $urandom_range(0, 5);
            case (pick)
                0:       v = 32'd1;
                1:       v = 32'd11;
                2, 3:    v = 32'd4;
                4:       v = 32'd2;
                default: v = $urandom | 32'h100;
            endcase
            a = (v == 32'd4) ? 32'($urandom_range(0, 32'h3F0)) : 32'($urandom);
            model(v, a);
            if (v != 32'd1 && v != 32'd11 && v != 32'd4) exp_bad = 1'b1;
            k = exp_items.size();
            base = (v == 32'd4) ? 3 + 3 * k : ((v == 32'd1 || v == 32'd11) ? 2 : 0);
            do_syscall(v, a, 0, 1'b1, sc, w);
            check("rnd_stall", 33'(sc), 33'(base + w));
            check("rnd_bad", 33'(bad_code), 33'(exp_bad));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
